event_window_ctrl: RTL and testbench

- Sequencer for one 32-bit gated event counter instance (start/din/cnt/cnt_full interface, active-low async clear).
- Accepts a measurement command (window length in cycles), clears the counter, gates it with start for exactly that many cycles, waits for the count to settle, then returns count plus saturation flag over a valid/ready result channel.
- Sits between the register/command layer and the counter datapath.

---
 rtl/event_window_ctrl_pkg.sv | 19 +
 rtl/event_window_timer.sv | 38 +++
 rtl/event_window_ctrl.sv | 134 +++++++++++++
 tb/tb_event_window_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/event_window_ctrl_pkg.sv
// Shared definitions for the event window controller.
//   - Default widths of the counter value and of the window-length field.
//   - Default saturation threshold.
//   - Controller state encoding.
package event_window_ctrl_pkg;

    localparam int          CNT_W_DEF   = 32;
    localparam int          LEN_W_DEF   = 32;
    localparam logic [31:0] SAT_THR_DEF = 32'hFFFF_FFFE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_SETTLE,
        ST_REPORT
    } ewc_state_e;

endpackage

// File: rtl/event_window_timer.sv
// Loadable down-counter that times the RUN window.
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : load load_val_i into the remaining count
//   load_val_i   : window length
//   en_i         : count down by one this cycle
//   done_o       : the current cycle is the last one of the window (remaining == 1)
module event_window_timer
    import event_window_ctrl_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [LEN_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             done_o
);

    logic [LEN_W-1:0] rem_q, rem_d;

    // The count parks at 1 instead of wrapping, so any LEN_W-bit length is legal.
    always_comb begin
        rem_d = rem_q;
        if (load_i)
            rem_d = load_val_i;
        else if (en_i && (rem_q > LEN_W'(1)))
            rem_d = rem_q - LEN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) rem_q <= '0;
        else     rem_q <= rem_d;
    end

    assign done_o = (rem_q == LEN_W'(1));

endmodule

// File: rtl/event_window_ctrl.sv
// Sequencer for one gated event counter: clear, gate for a commanded window,
// let the count settle, then return count / saturation / abort flags.
//   clk, rst              : clock, synchronous active-high reset
//   cmd_valid/ready/len   : measurement command (window length in cycles)
//   abort                 : end the running window early
//   cnt_start, cnt_clr_n  : registered gate and active-low clear towards the counter
//   cnt, cnt_full         : counter value and its saturation flag
//   res_*                 : result channel, valid/ready handshake
//   busy                  : controller is not in IDLE
module event_window_ctrl
    import event_window_ctrl_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter int               LEN_W   = LEN_W_DEF,
    parameter logic [CNT_W-1:0] SAT_THR = CNT_W'(SAT_THR_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort,
    output logic             cnt_start,
    output logic             cnt_clr_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic             cnt_full,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic             res_sat,
    output logic             res_abort,
    output logic             busy
);

    ewc_state_e       state_q, state_d;
    logic             start_q, start_d;
    logic             clr_n_q, clr_n_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;
    logic             abrt_q, abrt_d;
    logic             tmr_load, tmr_en, tmr_done;

    // The timer is loaded at command accept and holds through CLEAR, so it
    // doubles as the latched window length.
    event_window_timer #(.LEN_W(LEN_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (cmd_len),
        .en_i       (tmr_en),
        .done_o     (tmr_done)
    );

    always_comb begin
        state_d  = state_q;
        start_d  = 1'b0;
        clr_n_d  = 1'b1;
        count_d  = count_q;
        sat_d    = sat_q;
        abrt_d   = abrt_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    abrt_d = 1'b0;
                    if (cmd_len == '0) begin
                        // Empty window: report zero without touching the counter.
                        state_d = ST_REPORT;
                        count_d = '0;
                        sat_d   = 1'b0;
                    end else begin
                        state_d  = ST_CLEAR;
                        clr_n_d  = 1'b0;
                        tmr_load = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = ST_RUN;
                start_d = 1'b1;
            end
            ST_RUN: begin
                tmr_en = 1'b1;
                if (abort) begin
                    state_d = ST_SETTLE;
                    abrt_d  = 1'b1;
                end else if (tmr_done) begin
                    state_d = ST_SETTLE;
                end else begin
                    start_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                // The last gated increment landed on the edge that entered SETTLE.
                state_d = ST_REPORT;
                count_d = cnt;
                sat_d   = (cnt >= SAT_THR) | cnt_full;
            end
            ST_REPORT: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            clr_n_q <= 1'b1;
            count_q <= '0;
            sat_q   <= 1'b0;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            clr_n_q <= clr_n_d;
            count_q <= count_d;
            sat_q   <= sat_d;
            abrt_q  <= abrt_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign res_valid = (state_q == ST_REPORT);
    assign cnt_start = start_q;
    assign cnt_clr_n = clr_n_q;
    assign res_count = count_q;
    assign res_sat   = sat_q;
    assign res_abort = abrt_q;

endmodule

// File: tb/tb_event_window_ctrl.sv
module tb_event_window_ctrl;

    localparam logic [63:0] CMAX = 64'hFFFF_FFFF;
    localparam logic [63:0] STHR = 64'hFFFF_FFFE;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, abort;
    logic [31:0] cmd_len;
    logic        cnt_start, cnt_clr_n, cnt_full;
    logic [31:0] cnt;
    logic        res_valid, res_ready, res_sat, res_abort, busy;
    logic [31:0] res_count;
    logic        din;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_start = 0;
    int n_clr = 0;
    bit mdl_on = 0;
    logic [31:0] clr_val = '0;

    always #5 clk = ~clk;

    event_window_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .abort(abort), .cnt_start(cnt_start), .cnt_clr_n(cnt_clr_n),
        .cnt(cnt), .cnt_full(cnt_full), .res_valid(res_valid), .res_ready(res_ready),
        .res_count(res_count), .res_sat(res_sat), .res_abort(res_abort), .busy(busy)
    );

    // Gated, saturating event counter with async clear (clears to clr_val so a
    // near-full start value can be preloaded).
    logic [31:0] c_q = '0;
    always @(posedge clk or negedge cnt_clr_n) begin
        if (!cnt_clr_n)                              c_q <= clr_val;
        else if (cnt_start && din && c_q != 32'hFFFF_FFFF) c_q <= c_q + 32'd1;
    end
    assign cnt      = c_q;
    assign cnt_full = (c_q == 32'hFFFF_FFFF);

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cnt_start)  n_start++;
        if (!cnt_clr_n) n_clr++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Timeline model: a command accepted in cycle a with length L (effective
    // length Le after abort) clears in a+1, gates in a+2..a+Le+1 and reports
    // from a+Le+3 (a+1 when L==0) until the handshake.
    bit      m_active = 0;
    longint  m_a, m_L, m_Le, m_ones, m_base;
    bit      m_abort;

    always @(negedge clk) begin : model
        longint rel, ecnt;
        bit e_start, e_clr, e_rv;
        if (mdl_on) begin
            rel     = longint'(cyc) - m_a;
            e_clr   = m_active && m_L != 0 && rel == 1;
            e_start = m_active && m_L != 0 && rel >= 2 && rel <= m_Le + 1;
            e_rv    = m_active && ((m_L == 0 && rel >= 1) || (m_L != 0 && rel >= m_Le + 3));
            ecnt    = (m_L == 0) ? 0 : m_base + m_ones;
            if (ecnt > CMAX) ecnt = CMAX;
            chk("m_busy", busy, m_active);
            chk("m_cmd_ready", cmd_ready, !m_active);
            chk("m_cnt_start", cnt_start, e_start);
            chk("m_cnt_clr_n", cnt_clr_n, !e_clr);
            chk("m_res_valid", res_valid, e_rv);
            if (e_rv) begin
                chk("m_res_count", res_count, ecnt);
                chk("m_res_sat", res_sat, (ecnt >= STHR) ? 1 : 0);
                chk("m_res_abort", res_abort, m_abort);
            end
            if (rst) begin
                m_active = 0;
            end else if (m_active) begin
                if (e_start) begin
                    if (din) m_ones++;
                    if (abort) begin m_Le = rel - 1; m_abort = 1; end
                end
                if (e_rv && res_ready) m_active = 0;
            end else if (cmd_valid) begin
                m_active = 1; m_a = longint'(cyc); m_L = longint'(cmd_len); m_Le = m_L;
                m_ones = 0; m_abort = 0; m_base = longint'(clr_val);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // mode: 0 din=0, 1 din=1, 2 din toggles 1,0,... from the first gated cycle.
    task automatic run_cmd(input logic [31:0] len, input int mode, input int abort_at,
                           input int hold, input bit spam, output int lat,
                           output logic [31:0] rc, output logic rs, output logic ra,
                           output int starts, output int clrs);
        int rel, held, s0, c0;
        bit fin;
        rel = 0; held = 0; fin = 0; lat = -1; rc = '0; rs = 0; ra = 0;
        s0 = n_start; c0 = n_clr;
        chk("cmd_ready_before_accept", cmd_ready, 1);
        cmd_valid = 1; cmd_len = len; abort = 0; res_ready = 0; din = 0;
        while (!fin && rel < int'(len) + 40) begin
            tick(); rel++;
            cmd_valid = spam && !res_valid;
            cmd_len   = spam ? 32'd7 : len;
            res_ready = 0;
            din   = (mode == 1) ? 1'b1 : (mode == 2) ? (rel % 2 == 0) : 1'b0;
            abort = (abort_at != 0) && (rel == abort_at + 1);
            if (res_valid) begin
                if (lat < 0) begin lat = rel; rc = res_count; rs = res_sat; ra = res_abort; end
                if (held >= hold) begin
                    res_ready = 1; tick(); res_ready = 0; fin = 1;
                end else held++;
            end
        end
        din = 0; abort = 0; cmd_valid = 0;
        if (!fin) begin
            n_chk++; n_err++;
            $display("FAIL timeout: no result handshake for len %0d", len);
        end
        starts = n_start - s0; clrs = n_clr - c0;
    endtask

    int lat, st, cl;
    logic [31:0] rc;
    logic rs, ra;

    initial begin
        rst = 1; cmd_valid = 0; cmd_len = '0; abort = 0; res_ready = 0; din = 0;
        repeat (3) tick();
        chk("rst_cnt_start", cnt_start, 0);
        chk("rst_cnt_clr_n", cnt_clr_n, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_count", res_count, 0);
        chk("rst_res_sat", res_sat, 0);
        chk("rst_res_abort", res_abort, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        rst = 0; mdl_on = 1;
        tick();

        run_cmd(32'd5, 1, 0, 0, 0, lat, rc, rs, ra, st, cl);
        chk("l5_latency", lat, 8);
        chk("l5_count", rc, 5);
        chk("l5_sat", rs, 0);
        chk("l5_abort", ra, 0);
        chk("l5_start_cycles", st, 5);
        chk("l5_clr_pulses", cl, 1);

        run_cmd(32'd10, 2, 0, 0, 1, lat, rc, rs, ra, st, cl);
        chk("l10_toggle_count", rc, 5);
        chk("l10_start_cycles", st, 10);
        run_cmd(32'd3, 1, 0, 0, 0, lat, rc, rs, ra, st, cl);
        chk("l3_count_after_clear", rc, 3);
        chk("l3_clr_pulses", cl, 1);

        run_cmd(32'd0, 1, 0, 0, 0, lat, rc, rs, ra, st, cl);
        chk("l0_latency", lat, 1);
        chk("l0_count", rc, 0);
        chk("l0_start_cycles", st, 0);
        chk("l0_clr_pulses", cl, 0);

        run_cmd(32'd100, 1, 20, 0, 0, lat, rc, rs, ra, st, cl);
        chk("abort_count", rc, 20);
        chk("abort_flag", ra, 1);
        chk("abort_start_cycles", st, 20);
        chk("abort_latency", lat, 23);

        clr_val = 32'hFFFF_FFFD;
        run_cmd(32'd8, 1, 0, 0, 0, lat, rc, rs, ra, st, cl);
        chk("sat_count", rc, 32'hFFFF_FFFF);
        chk("sat_flag", rs, 1);
        chk("sat_abort_cleared", ra, 0);
        clr_val = '0;

        run_cmd(32'd4, 1, 0, 4, 0, lat, rc, rs, ra, st, cl);
        chk("hold_latency", lat, 7);
        chk("hold_count", rc, 4);

        // Reset in the middle of a long window.
        cmd_valid = 1; cmd_len = 32'd50; tick();
        cmd_valid = 0; din = 1;
        repeat (10) tick();
        rst = 1; tick(); rst = 0; din = 0;
        chk("midrst_cnt_start", cnt_start, 0);
        chk("midrst_res_valid", res_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_res_count", res_count, 0);
        repeat (60) tick();
        chk("midrst_no_result", res_valid, 0);

        run_cmd(32'd2, 1, 0, 0, 0, lat, rc, rs, ra, st, cl);
        chk("after_rst_count", rc, 2);
        chk("after_rst_latency", lat, 5);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
